// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - single-clock run/pause/adjust sequencer for the stopwatch datapath
module stopwatch_ctrl #(
  parameter int TICK_1HZ_DIV = 100_000_000,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic clk1,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_clear,
  input  logic sel_switch,
  input  logic adj_switch,
  output logic count_en,
  output logic clear,
  output logic adj_mode,
  output logic adj_sel,
  output logic paused,
  output logic blink
);

  localparam int HALF = TICK_1HZ_DIV / 2;
  localparam int PW   = $clog2(HALF + 1);
  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int BW   = $clog2(BLINK_DIV + 1);

  localparam logic [PW-1:0] P_LAST = PW'(HALF - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DB_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  // Encoding: bit1 = adjust, bit0 = paused, so the two axes update independently.
  typedef enum logic [1:0] {
    RUN        = 2'b00,
    PAUSED     = 2'b01,
    ADJ_RUN    = 2'b10,
    ADJ_PAUSED = 2'b11
  } state_t;

  state_t state;

  // Raw inputs packed as {adj, sel, clear, pause}; bits 0/1 are the buttons.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;

  logic [1:0]         level;
  logic [1:0]         press;
  logic [1:0][DW-1:0] db_cnt;

  logic          pause_press;
  logic          clear_press;
  logic          adj_s;
  logic          sel_s;

  logic [PW-1:0] pre_cnt;
  logic          pre_phase;
  logic          running;
  logic          wrap;
  logic          tick_1hz;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          next_paused;
  logic          next_adj;

  assign raw         = {adj_switch, sel_switch, btn_clear, btn_pause};
  assign pause_press = press[0];
  assign clear_press = press[1];
  assign sel_s       = sync2[2];
  assign adj_s       = sync2[3];

  // Two-flop synchroniser for every asynchronous input.
  always_ff @(posedge clk1) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce both buttons; a press pulse is emitted only on an accepted 0->1 change.
  always_ff @(posedge clk1) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
          press[i]  <= 1'b0;
        end else if (db_cnt[i] == D_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
          press[i]  <= 1'b0;
        end
      end
    end
  end

  assign running  = (state == RUN) || (state == ADJ_RUN);
  assign wrap     = running && (pre_cnt == P_LAST);
  assign tick_1hz = wrap && pre_phase;

  // Half-second prescaler; frozen while paused so the fractional second survives.
  always_ff @(posedge clk1) begin
    if (rst || clear_press) begin
      pre_cnt   <= '0;
      pre_phase <= 1'b0;
    end else if (running) begin
      if (pre_cnt == P_LAST) begin
        pre_cnt   <= '0;
        pre_phase <= ~pre_phase;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign next_paused = state[0] ^ pause_press;
  assign next_adj    = adj_s;

  // Mode FSM with registered strobes; a clear press swallows a coincident tick.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state    <= RUN;
      count_en <= 1'b0;
      clear    <= 1'b0;
      adj_mode <= 1'b0;
      adj_sel  <= 1'b0;
      paused   <= 1'b0;
    end else begin
      state    <= state_t'({next_adj, next_paused});
      paused   <= next_paused;
      adj_mode <= next_adj;
      adj_sel  <= sel_s;
      clear    <= clear_press;
      count_en <= !clear_press &&
                  (((state == RUN) && tick_1hz) || ((state == ADJ_RUN) && wrap));
    end
  end

  // Blink phase generator, parked at zero outside adjust mode.
  always_ff @(posedge clk1) begin
    if (rst || !adj_mode) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == B_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink = adj_mode & blink_phase;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic clk1 = 1'b0;
  logic rst;
  logic btn_pause;
  logic btn_clear;
  logic sel_switch;
  logic adj_switch;
  logic count_en;
  logic clear;
  logic adj_mode;
  logic adj_sel;
  logic paused;
  logic blink;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Level expectation: signal id 0=paused 1=adj_mode 2=adj_sel 3=blink.
  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } exp_t;

  exp_t exp_q[$];
  int   ce_q[$];
  int   clr_q[$];

  stopwatch_ctrl #(
    .TICK_1HZ_DIV(8),
    .DB_CYCLES   (4),
    .BLINK_DIV   (3)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .sel_switch(sel_switch),
    .adj_switch(adj_switch),
    .count_en  (count_en),
    .clear     (clear),
    .adj_mode  (adj_mode),
    .adj_sel   (adj_sel),
    .paused    (paused),
    .blink     (blink)
  );

  always #5 clk1 = ~clk1;

  function automatic logic sig_val(input int s);
    case (s)
      0:       return paused;
      1:       return adj_mode;
      2:       return adj_sel;
      default: return blink;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0:       return "paused";
      1:       return "adj_mode";
      2:       return "adj_sel";
      default: return "blink";
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, want);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, want);
    end
  endtask

  task automatic expect_lvl(input int c, input int s, input logic v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then score strobes every cycle and any due level checks.
  task automatic step();
    logic want_ce;
    logic want_clr;
    @(posedge clk1);
    #1;
    cyc++;
    want_ce  = 1'b0;
    want_clr = 1'b0;
    for (int i = ce_q.size() - 1; i >= 0; i--) begin
      if (ce_q[i] == cyc) begin
        want_ce = 1'b1;
        ce_q.delete(i);
      end
    end
    for (int i = clr_q.size() - 1; i >= 0; i--) begin
      if (clr_q[i] == cyc) begin
        want_clr = 1'b1;
        clr_q.delete(i);
      end
    end
    chk("count_en", count_en, want_ce);
    chk("clear", clear, want_clr);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        chk(sig_name(exp_q[i].sig), sig_val(exp_q[i].sig), exp_q[i].val);
        exp_q.delete(i);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Apply reset for one edge; that edge becomes cycle 0 and all outputs must be low.
  task automatic do_reset();
    chk_int("pending_before_reset", exp_q.size() + ce_q.size() + clr_q.size(), 0);
    exp_q.delete();
    ce_q.delete();
    clr_q.delete();
    rst = 1'b1;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk("rst_count_en", count_en, 1'b0);
    chk("rst_clear", clear, 1'b0);
    chk("rst_adj_mode", adj_mode, 1'b0);
    chk("rst_adj_sel", adj_sel, 1'b0);
    chk("rst_paused", paused, 1'b0);
    chk("rst_blink", blink, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    btn_pause  = 1'b0;
    btn_clear  = 1'b0;
    sel_switch = 1'b0;
    adj_switch = 1'b0;

    // Free run: 1 Hz strobes at 8, 16, 24.
    do_reset();
    ce_q.push_back(8);
    ce_q.push_back(16);
    ce_q.push_back(24);
    expect_lvl(26, 0, 1'b0);
    expect_lvl(26, 1, 1'b0);
    steps(26);

    // Bounce rejected, long press pauses at 24+6, resume keeps the remaining count.
    do_reset();
    ce_q.push_back(8);
    ce_q.push_back(16);
    ce_q.push_back(24);
    ce_q.push_back(59);
    ce_q.push_back(67);
    expect_lvl(29, 0, 1'b0);
    expect_lvl(30, 0, 1'b1);
    expect_lvl(56, 0, 1'b1);
    expect_lvl(57, 0, 1'b0);
    steps(1);
    btn_pause = 1'b1;
    steps(2);
    btn_pause = 1'b0;
    steps(20);
    btn_pause = 1'b1;
    steps(10);
    btn_pause = 1'b0;
    steps(17);
    btn_pause = 1'b1;
    steps(6);
    btn_pause = 1'b0;
    steps(12);

    // Adjust mode: 2 Hz strobes, blink every 3 cycles, then back to 1 Hz.
    do_reset();
    for (int t = 4; t <= 24; t += 4) ce_q.push_back(t);
    ce_q.push_back(32);
    expect_lvl(2, 1, 1'b0);
    expect_lvl(3, 1, 1'b1);
    expect_lvl(2, 2, 1'b0);
    expect_lvl(3, 2, 1'b1);
    expect_lvl(5, 3, 1'b0);
    expect_lvl(6, 3, 1'b1);
    expect_lvl(8, 3, 1'b1);
    expect_lvl(9, 3, 1'b0);
    expect_lvl(12, 3, 1'b1);
    expect_lvl(12, 0, 1'b0);
    expect_lvl(23, 1, 1'b1);
    expect_lvl(24, 1, 1'b0);
    expect_lvl(24, 3, 1'b0);
    adj_switch = 1'b1;
    sel_switch = 1'b1;
    steps(21);
    adj_switch = 1'b0;
    steps(12);
    sel_switch = 1'b0;

    // Clear press lands on the 1 Hz tick at 16: clear wins, next strobe 8 later.
    do_reset();
    ce_q.push_back(8);
    ce_q.push_back(24);
    ce_q.push_back(32);
    clr_q.push_back(16);
    expect_lvl(20, 0, 1'b0);
    steps(9);
    btn_clear = 1'b1;
    steps(6);
    btn_clear = 1'b0;
    steps(18);

    // Pause press and adj rise in the same cycle: RUN -> ADJ_PAUSED, no strobes.
    do_reset();
    expect_lvl(6, 0, 1'b0);
    expect_lvl(6, 1, 1'b0);
    expect_lvl(7, 0, 1'b1);
    expect_lvl(7, 1, 1'b1);
    expect_lvl(24, 0, 1'b1);
    expect_lvl(24, 3, 1'b1);
    btn_pause = 1'b1;
    steps(4);
    adj_switch = 1'b1;
    steps(2);
    btn_pause = 1'b0;
    steps(14);

    // Reset in ADJ_PAUSED with a clear debounce half counted: press is lost.
    btn_clear = 1'b1;
    steps(4);
    do_reset();
    btn_clear  = 1'b0;
    adj_switch = 1'b0;
    ce_q.push_back(8);
    expect_lvl(5, 0, 1'b0);
    expect_lvl(5, 1, 1'b0);
    steps(12);

    chk_int("leftover_expectations", exp_q.size() + ce_q.size() + clr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
